// File: rtl/dtc_pulsegen.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | dtc_pulsegen: timestamp-driven pulse generator with event FIFO, CSR bank |
// | and 8:1 serializer word output.                Revision: 1.0             |
// +--------------------------------------------------------------------------+
module dtc_pulsegen #(
   parameter logic [3:0] csr_addr   = 4'h0,
   parameter int         fifo_depth = 8
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [13:0] csr_a,
   input  logic        csr_we,
   input  logic [31:0] csr_di,
   output logic [31:0] csr_do,
   output logic        irq,
   output logic [7:0]  serdes_o
);

   localparam int c_aw = $clog2(fifo_depth);
   localparam int c_cw = c_aw + 1;

   logic              en_q, en_d;
   logic              level_q, level_d;
   logic              late_q, late_d;
   logic              ovf_q, ovf_d;
   logic [2:0]        mask_q, mask_d;
   logic [28:0]       cnt_q, cnt_d;
   logic [c_aw-1:0]   wr_ptr_q, wr_ptr_d;
   logic [c_aw-1:0]   rd_ptr_q, rd_ptr_d;
   logic [c_cw-1:0]   fill_q, fill_d;
   logic [31:0]       mem_q [fifo_depth];
   logic [7:0]        serdes_q, serdes_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              irq_q, irq_d;

   logic              sel;
   logic [2:0]        off;
   logic              wr_ctrl, wr_cnt, wr_push, wr_stat, wr_mask;
   logic              empty, full;
   logic [31:0]       head;
   logic [28:0]       diff;
   logic              fire, late_ev, pop, flush, push_ok, ovf_ev;
   logic              unused_addr;

   assign unused_addr = ^csr_a[9:3];

   always_comb begin
      sel     = (csr_a[13:10] == csr_addr);
      off     = csr_a[2:0];
      wr_ctrl = csr_we && sel && (off == 3'd0);
      wr_cnt  = csr_we && sel && (off == 3'd1);
      wr_push = csr_we && sel && (off == 3'd2);
      wr_stat = csr_we && sel && (off == 3'd3);
      wr_mask = csr_we && sel && (off == 3'd4);
      empty   = (fill_q == '0);
      full    = (fill_q == c_cw'(fifo_depth));
      head    = mem_q[rd_ptr_q];
      // Modular distance to the head timestamp; its MSB flags an event in the past.
      diff    = head[31:3] - cnt_q;
      fire    = en_q && !empty && (diff == '0);
      late_ev = en_q && !empty && diff[28];
      pop     = fire || late_ev;
      flush   = wr_ctrl && csr_di[2];
      push_ok = wr_push && !flush && (!full || pop);
      ovf_ev  = wr_push && !flush && full && !pop;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (wr_cnt) begin
         cnt_d = csr_di[28:0];
      end else if (en_q) begin
         cnt_d = cnt_q + 29'd1;
      end

      en_d    = wr_ctrl ? csr_di[0] : en_q;
      level_d = level_q;
      if (fire) begin
         level_d = ~level_q;
      end
      if (wr_ctrl && !en_q) begin
         level_d = csr_di[1];
      end

      late_d = (late_q && !(wr_stat && csr_di[0])) || late_ev;
      ovf_d  = (ovf_q  && !(wr_stat && csr_di[1])) || ovf_ev;
      mask_d = wr_mask ? csr_di[2:0] : mask_q;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         fill_d   = '0;
      end else begin
         if (push_ok) begin
            wr_ptr_d = wr_ptr_q + c_aw'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + c_aw'(1);
         end
         if (push_ok && !pop) begin
            fill_d = fill_q + c_cw'(1);
         end else if (!push_ok && pop) begin
            fill_d = fill_q - c_cw'(1);
         end
      end
   end

   // Bits before the fine offset keep the old level, the rest carry the new one.
   always_comb begin
      serdes_d = {8{level_q}};
      for (int i = 0; i < 8; i++) begin
         if (fire && (3'(i) >= head[2:0])) begin
            serdes_d[i] = ~level_q;
         end
      end
   end

   always_comb begin
      rdata_d = '0;
      if (sel) begin
         case (off)
            3'd0:    rdata_d = {29'd0, 1'b0, level_q, en_q};
            3'd1:    rdata_d = {3'd0, cnt_q};
            3'd2:    rdata_d = {{(32-c_cw){1'b0}}, fill_q};
            3'd3:    rdata_d = {29'd0, empty, ovf_q, late_q};
            3'd4:    rdata_d = {29'd0, mask_q};
            default: rdata_d = '0;
         endcase
      end
      irq_d = |({empty, ovf_q, late_q} & mask_q);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         en_q     <= 1'b0;
         level_q  <= 1'b0;
         late_q   <= 1'b0;
         ovf_q    <= 1'b0;
         mask_q   <= '0;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         serdes_q <= '0;
         rdata_q  <= '0;
         irq_q    <= 1'b0;
      end else begin
         en_q     <= en_d;
         level_q  <= level_d;
         late_q   <= late_d;
         ovf_q    <= ovf_d;
         mask_q   <= mask_d;
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         serdes_q <= serdes_d;
         rdata_q  <= rdata_d;
         irq_q    <= irq_d;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= csr_di;
      end
   end

   assign csr_do   = rdata_q;
   assign irq      = irq_q;
   assign serdes_o = serdes_q;

endmodule
`default_nettype wire

// File: tb/tb_dtc_pulsegen.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dtc_pulsegen: table vectors, directed corner sequences and random     |
// | traffic against a queue-based reference model.       Revision: 1.0      |
// +--------------------------------------------------------------------------+
module tb_dtc_pulsegen;

   localparam logic [3:0] PAGE  = 4'h5;
   localparam int         DEPTH = 8;
   localparam longint     MOD   = 64'd1 << 29;

   logic        sys_clk   = 1'b0;
   logic        sys_rst_n = 1'b1;
   logic [13:0] csr_a     = '0;
   logic        csr_we    = 1'b0;
   logic [31:0] csr_di    = '0;
   logic [31:0] csr_do;
   logic        irq;
   logic [7:0]  serdes_o;

   dtc_pulsegen #(.csr_addr(PAGE), .fifo_depth(DEPTH)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .csr_a     (csr_a),
      .csr_we    (csr_we),
      .csr_di    (csr_di),
      .csr_do    (csr_do),
      .irq       (irq),
      .serdes_o  (serdes_o)
   );

   always #5 sys_clk = ~sys_clk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   longint      m_cnt;
   bit          m_en, m_level, m_late, m_ovf;
   bit [2:0]    m_mask;
   logic [31:0] m_q[$];
   logic [7:0]  m_ser;
   logic [31:0] m_do;
   logic        m_irq;

   typedef struct {
      bit          we;
      bit          on_page;
      logic [2:0]  off;
      logic [31:0] di;
      logic [31:0] exp_do;
      bit          exp_irq;
      logic [7:0]  exp_ser;
   } vec_t;

   vec_t tbl[18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: actual=%08h required=%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [13:0] adr(input int off);
      return {PAGE, 7'd0, 3'(off)};
   endfunction

   function automatic logic [13:0] badadr(input int off);
      return {PAGE ^ 4'h3, 7'd0, 3'(off)};
   endfunction

   function automatic logic [31:0] m_reg(input int off);
      case (off)
         0:       return {30'd0, m_level, m_en};
         1:       return 32'(m_cnt);
         2:       return 32'(m_q.size());
         3:       return {29'd0, (m_q.size() == 0), m_ovf, m_late};
         4:       return {29'd0, m_mask};
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_en = 0; m_level = 0; m_late = 0; m_ovf = 0; m_mask = 0;
      m_q.delete();
      m_ser = 0; m_do = 0; m_irq = 0;
   endtask

   // One clock edge of behaviour, expressed from the register-level rules.
   task automatic model_step(input logic we, input logic [13:0] a, input logic [31:0] di);
      bit          sel, fire, lt, old_en, wr;
      int          off, fine;
      longint      d;
      logic [31:0] h;
      sel  = (a[13:10] == PAGE);
      off  = int'(a[2:0]);
      wr   = we && sel;
      m_do  = sel ? m_reg(off) : 32'd0;
      m_irq = ((m_q.size() == 0) && m_mask[2]) || (m_ovf && m_mask[1]) || (m_late && m_mask[0]);
      fire = 0;
      lt   = 0;
      h    = 0;
      if (m_en && m_q.size() > 0) begin
         h = m_q[0];
         d = (longint'(h[31:3]) - m_cnt + MOD) % MOD;
         if (d == 0) fire = 1;
         else if (d >= MOD / 2) lt = 1;
      end
      if (fire) begin
         fine = int'(h[2:0]);
         for (int i = 0; i < 8; i++) m_ser[i] = (i < fine) ? m_level : !m_level;
      end else begin
         m_ser = {8{m_level}};
      end
      if (fire || lt) void'(m_q.pop_front());
      if (fire) m_level = !m_level;
      if (wr && off == 3 && di[0]) m_late = 0;
      if (wr && off == 3 && di[1]) m_ovf = 0;
      if (lt) m_late = 1;
      old_en = m_en;
      if (wr && off == 1) m_cnt = longint'(di[28:0]);
      else if (old_en) m_cnt = (m_cnt + 1) % MOD;
      if (wr && off == 0) begin
         m_en = di[0];
         if (!old_en) m_level = di[1];
         if (di[2]) m_q.delete();
      end
      if (wr && off == 2) begin
         if (m_q.size() < DEPTH) m_q.push_back(di);
         else m_ovf = 1;
      end
      if (wr && off == 4) m_mask = di[2:0];
   endtask

   task automatic cyc(input logic we, input logic [13:0] a, input logic [31:0] di);
      csr_we = we;
      csr_a  = a;
      csr_di = di;
      @(posedge sys_clk);
      model_step(we, a, di);
      #1;
      chk("mdl_serdes", {24'd0, serdes_o}, {24'd0, m_ser});
      chk("mdl_csr_do", csr_do, m_do);
      chk("mdl_irq", {31'd0, irq}, {31'd0, m_irq});
      csr_we = 1'b0;
   endtask

   task automatic wr(input int off, input logic [31:0] d);
      cyc(1'b1, adr(off), d);
   endtask

   task automatic rd(input int off);
      cyc(1'b0, adr(off), 32'd0);
   endtask

   task automatic apply_reset();
      csr_we    = 1'b0;
      sys_rst_n = 1'b0;
      #1;
      chk("rst_serdes", {24'd0, serdes_o}, 32'd0);
      chk("rst_csr_do", csr_do, 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      @(posedge sys_clk);
      @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          found;
      logic [31:0] d;
      longint      c;
      int          op;

      tbl[0]  = '{0, 1, 3'd3, 32'h0,        32'h4,        0, 8'h00};
      tbl[1]  = '{1, 1, 3'd4, 32'h7,        32'h0,        0, 8'h00};
      tbl[2]  = '{0, 1, 3'd4, 32'h0,        32'h7,        1, 8'h00};
      tbl[3]  = '{1, 1, 3'd0, 32'h2,        32'h0,        1, 8'h00};
      tbl[4]  = '{0, 1, 3'd0, 32'h0,        32'h2,        1, 8'hFF};
      tbl[5]  = '{1, 1, 3'd1, 32'hFFFFFFFF, 32'h0,        1, 8'hFF};
      tbl[6]  = '{0, 1, 3'd1, 32'h0,        32'h1FFFFFFF, 1, 8'hFF};
      tbl[7]  = '{1, 1, 3'd2, 32'h53,       32'h0,        1, 8'hFF};
      tbl[8]  = '{0, 1, 3'd2, 32'h0,        32'h1,        0, 8'hFF};
      tbl[9]  = '{0, 1, 3'd3, 32'h0,        32'h0,        0, 8'hFF};
      tbl[10] = '{1, 0, 3'd4, 32'h0,        32'h0,        0, 8'hFF};
      tbl[11] = '{0, 1, 3'd4, 32'h0,        32'h7,        0, 8'hFF};
      tbl[12] = '{1, 1, 3'd0, 32'h6,        32'h2,        0, 8'hFF};
      tbl[13] = '{0, 1, 3'd2, 32'h0,        32'h0,        1, 8'hFF};
      tbl[14] = '{1, 1, 3'd5, 32'hFFFF,     32'h0,        1, 8'hFF};
      tbl[15] = '{0, 1, 3'd0, 32'h0,        32'h2,        1, 8'hFF};
      tbl[16] = '{1, 1, 3'd4, 32'h0,        32'h7,        1, 8'hFF};
      tbl[17] = '{0, 1, 3'd3, 32'h0,        32'h4,        0, 8'hFF};

      model_reset();
      #2;
      apply_reset();

      // Register-level vectors
      for (int i = 0; i < 18; i++) begin
         cyc(tbl[i].we, tbl[i].on_page ? adr(int'(tbl[i].off)) : badadr(int'(tbl[i].off)), tbl[i].di);
         chk($sformatf("tbl%0d_do", i), csr_do, tbl[i].exp_do);
         chk($sformatf("tbl%0d_irq", i), {31'd0, irq}, {31'd0, tbl[i].exp_irq});
         chk($sformatf("tbl%0d_ser", i), {24'd0, serdes_o}, {24'd0, tbl[i].exp_ser});
      end

      // Fine placement, then full-word toggle back to 0
      apply_reset();
      wr(1, 32'd0);
      wr(2, 32'h53);
      wr(0, 32'h1);
      for (int j = 1; j <= 14; j++) begin
         rd(1);
         chk($sformatf("fine_j%0d", j), {24'd0, serdes_o}, (j < 11) ? 32'h00 : ((j == 11) ? 32'hF8 : 32'hFF));
      end
      rd(0);
      chk("fine_level", csr_do, 32'h3);
      wr(0, 32'h0);
      wr(1, 32'd0);
      wr(2, 32'hA0);
      wr(0, 32'h3);
      for (int j = 1; j <= 23; j++) begin
         rd(1);
         chk($sformatf("toggle_j%0d", j), {24'd0, serdes_o}, (j < 21) ? 32'hFF : 32'h00);
      end
      rd(0);
      chk("toggle_level", csr_do, 32'h1);

      // Late event, then duplicate timestamps
      apply_reset();
      wr(1, 32'd100);
      wr(0, 32'h1);
      wr(2, 32'h190);
      rd(3);
      rd(3);
      chk("late_status", csr_do, 32'h5);
      chk("late_no_toggle", {24'd0, serdes_o}, 32'h0);
      wr(3, 32'h3);
      rd(3);
      chk("late_cleared", csr_do, 32'h4);
      wr(2, 32'h640);
      wr(2, 32'h640);
      found = 0;
      for (int k = 0; k < 150 && !found; k++) begin
         rd(2);
         if (serdes_o == 8'hFF) found = 1;
      end
      chk("dup_first_fired", {31'd0, found}, 32'd1);
      rd(3);
      rd(2);
      chk("dup_fill", csr_do, 32'h0);
      rd(3);
      chk("dup_status", csr_do, 32'h5);
      rd(0);
      chk("dup_level", csr_do, 32'h3);

      // Overflow and masked interrupt
      apply_reset();
      for (int k = 0; k < 9; k++) wr(2, $urandom);
      rd(2);
      chk("ovf_fill", csr_do, 32'd8);
      rd(3);
      chk("ovf_status", csr_do, 32'h2);
      wr(4, 32'h2);
      rd(3);
      chk("ovf_irq_set", {31'd0, irq}, 32'd1);
      wr(3, 32'h2);
      rd(3);
      chk("ovf_cleared", csr_do, 32'h0);
      chk("ovf_irq_clr", {31'd0, irq}, 32'd0);

      // Counter wrap-around
      apply_reset();
      wr(1, 32'h1FFFFFFE);
      wr(2, 32'h8);
      wr(0, 32'h1);
      for (int j = 1; j <= 6; j++) begin
         rd(3);
         chk($sformatf("wrap_j%0d", j), {24'd0, serdes_o}, (j < 4) ? 32'h00 : 32'hFF);
      end
      chk("wrap_not_late", csr_do, 32'h4);

      // Asynchronous reset with events queued
      apply_reset();
      wr(0, 32'h3);
      for (int k = 0; k < 4; k++) wr(2, (32'd1000 + 32'(k)) << 3);
      rd(2);
      chk("arst_fill", csr_do, 32'd4);
      chk("arst_ser_pre", {24'd0, serdes_o}, 32'hFF);
      rd(0);
      chk("arst_ctrl_pre", csr_do, 32'h3);
      apply_reset();
      rd(2);
      chk("arst_fill_post", csr_do, 32'd0);
      rd(0);
      chk("arst_ctrl_post", csr_do, 32'd0);

      // Random traffic against the model
      apply_reset();
      wr(4, 32'($urandom_range(0, 7)));
      for (int n = 0; n < 3000; n++) begin
         op = int'($urandom_range(0, 99));
         if (op < 35) begin
            c = (m_cnt + longint'($urandom_range(0, 40)) - 5 + MOD) % MOD;
            d = {29'(c), 3'($urandom_range(0, 7))};
            wr(2, d);
         end else if (op < 60) begin
            rd(int'($urandom_range(0, 7)));
         end else if (op < 68) begin
            d = {29'd0, ($urandom_range(0, 15) == 0), 1'($urandom), ($urandom_range(0, 3) != 0)};
            wr(0, d);
         end else if (op < 74) begin
            wr(3, 32'($urandom_range(0, 3)));
         end else if (op < 78) begin
            wr(4, 32'($urandom_range(0, 7)));
         end else if (op < 82) begin
            d = ($urandom_range(0, 1) == 1) ? (32'h1FFFFFFF - 32'($urandom_range(0, 8))) : 32'($urandom_range(0, 300));
            wr(1, d);
         end else if (op < 88) begin
            cyc(1'b1, badadr(int'($urandom_range(0, 7))), $urandom);
         end else begin
            rd(2);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
